hnoc_out_arbiter: RTL and testbench

- Shares one switch output port among NumIn input ports of an HNoC switch.
- Arbitration is round-robin with bounded bursts; an output register stage follows the arbiter.
- Each requester presents a beat already routed to this output, using the valid/ready handshake used throughout the NoC.
- One instance sits in front of each switch output (top, bottom, right) in the mclk domain.

---
 rtl/hnoc_out_arbiter_pkg.sv | 12 +
 rtl/hnoc_out_arbiter_rr_pick.sv | 28 ++
 rtl/hnoc_out_arbiter.sv | 134 +++++++++++++
 tb/tb_hnoc_out_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hnoc_out_arbiter_pkg.sv
// Shared HNoC switch definitions: arbiter FSM encoding and default switch dimensions.
package hnoc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } hnoc_state_e;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int NUM_SWITCH_PORTS   = 3;

endpackage

// File: rtl/hnoc_out_arbiter_rr_pick.sv
// Round-robin selector: one-hot winner is the first valid requester strictly after rr_ptr.
module hnoc_rr_pick #(
    parameter int NumIn    = 3,
    parameter int PtrWidth = $clog2(NumIn)
) (
    input  logic [NumIn-1:0]    valid_vec,
    input  logic [PtrWidth-1:0] rr_ptr,
    output logic [NumIn-1:0]    winner,
    output logic                any_valid
);

    logic found_s;
    int   idx_s;

    // Cyclic scan starting one past the last owner; the first valid hit masks all later ones.
    always_comb begin
        winner    = '0;
        found_s   = 1'b0;
        idx_s     = 0;
        any_valid = |valid_vec;
        for (int i = 1; i <= NumIn; i++) begin
            idx_s         = (int'(rr_ptr) + i) % NumIn;
            winner[idx_s] = valid_vec[idx_s] & ~found_s;
            found_s       = found_s | valid_vec[idx_s];
        end
    end

endmodule

// File: rtl/hnoc_out_arbiter.sv
// Output-port arbiter for an HNoC switch: round-robin with bounded bursts feeding an output register.
module hnoc_out_arbiter
    import hnoc_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH_DEFAULT,
    parameter int NumIn     = NUM_SWITCH_PORTS,
    parameter int BurstMax  = 4
) (
    input  logic                       i_mclk,
    input  logic                       i_reset_n,
    input  logic [NumIn*DataWidth-1:0] i_req_data,
    input  logic [NumIn-1:0]           i_req_valid,
    output logic [NumIn-1:0]           o_req_ready,
    output logic [DataWidth-1:0]       o_data,
    output logic                       o_data_valid,
    input  logic                       i_data_ready,
    output logic [NumIn-1:0]           o_grant,
    output logic                       o_busy
);

    localparam int PtrWidth = $clog2(NumIn);
    localparam int CntWidth = $clog2(BurstMax + 1);
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(BurstMax - 1);
    localparam logic [PtrWidth-1:0] PtrInit  = PtrWidth'(NumIn - 1);

    hnoc_state_e           state_r;
    logic [PtrWidth-1:0]   rr_ptr_r;
    logic [CntWidth-1:0]   beat_cnt_r;
    logic [NumIn-1:0]      grant_r;
    logic [DataWidth-1:0]  data_r;
    logic                  data_valid_r;

    logic                  load_en_s;
    logic                  in_grant_s;
    logic                  owner_valid_s;
    logic [DataWidth-1:0]  owner_data_s;
    logic [PtrWidth-1:0]   owner_idx_s;
    logic                  accept_s;
    logic                  release_s;
    logic [NumIn-1:0]      pick_s;
    logic                  pick_any_s;

    hnoc_rr_pick #(
        .NumIn    (NumIn),
        .PtrWidth (PtrWidth)
    ) u_pick (
        .valid_vec (i_req_valid),
        .rr_ptr    (rr_ptr_r),
        .winner    (pick_s),
        .any_valid (pick_any_s)
    );

    // Owner decode from the one-hot grant: data mux, index and valid of the current owner.
    always_comb begin
        owner_data_s  = '0;
        owner_idx_s   = '0;
        owner_valid_s = |(i_req_valid & grant_r);
        for (int k = 0; k < NumIn; k++) begin
            owner_data_s = owner_data_s | ({DataWidth{grant_r[k]}} & i_req_data[k*DataWidth +: DataWidth]);
            owner_idx_s  = owner_idx_s | (grant_r[k] ? PtrWidth'(k) : '0);
        end
    end

    // Handshake and release decisions; ready depends only on registered state and downstream ready.
    always_comb begin
        load_en_s   = !data_valid_r || i_data_ready;
        in_grant_s  = (state_r == GRANT);
        accept_s    = in_grant_s && owner_valid_s && load_en_s;
        release_s   = in_grant_s &&
                      ((accept_s && (beat_cnt_r == LastBeat)) || (load_en_s && !owner_valid_s));
        o_req_ready = in_grant_s ? (grant_r & {NumIn{load_en_s}}) : '0;
    end

    // Arbitration FSM, burst counter and round-robin pointer.
    always_ff @(posedge i_mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= IDLE;
            rr_ptr_r   <= PtrInit;
            beat_cnt_r <= '0;
            grant_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        grant_r    <= pick_s;
                        beat_cnt_r <= '0;
                        state_r    <= GRANT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                GRANT: begin
                    // A beat accepted in the release cycle is still captured by the output register.
                    if (release_s) begin
                        state_r    <= IDLE;
                        rr_ptr_r   <= owner_idx_s;
                        grant_r    <= '0;
                        beat_cnt_r <= '0;
                    end else if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r + CntWidth'(1);
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    grant_r    <= '0;
                    beat_cnt_r <= '0;
                end
            endcase
        end
    end

    // Output register: load on accept, drain when downstream takes the beat, otherwise hold.
    always_ff @(posedge i_mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_r       <= '0;
            data_valid_r <= 1'b0;
        end else if (accept_s) begin
            data_r       <= owner_data_s;
            data_valid_r <= 1'b1;
        end else if (i_data_ready) begin
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= data_valid_r;
        end
    end

    assign o_data       = data_r;
    assign o_data_valid = data_valid_r;
    assign o_grant      = grant_r;
    assign o_busy       = (state_r == GRANT);

endmodule

// File: tb/tb_hnoc_out_arbiter.sv
// Directed bench for hnoc_out_arbiter: one instance with BurstMax=4, one with BurstMax=2.
module tb_hnoc_out_arbiter;

    logic        clk;
    logic        rst_n;
    logic [95:0] rd4, rd2;
    logic [2:0]  rv4, rv2, rr4, rr2, og4, og2;
    logic [31:0] od4, od2;
    logic        ov4, ov2, ob4, ob2, dr4, dr2;

    // Per-instance (0: BurstMax=4, 1: BurstMax=2) per-requester flit sources.
    logic [31:0] src [2][3][8];
    int          cnt [2][3];
    int          ptr [2][3];
    logic        en  [2][3];

    int checks = 0;
    int errors = 0;

    hnoc_out_arbiter #(.DataWidth(32), .NumIn(3), .BurstMax(4)) dut4 (
        .i_mclk(clk), .i_reset_n(rst_n), .i_req_data(rd4), .i_req_valid(rv4),
        .o_req_ready(rr4), .o_data(od4), .o_data_valid(ov4), .i_data_ready(dr4),
        .o_grant(og4), .o_busy(ob4)
    );

    hnoc_out_arbiter #(.DataWidth(32), .NumIn(3), .BurstMax(2)) dut2 (
        .i_mclk(clk), .i_reset_n(rst_n), .i_req_data(rd2), .i_req_valid(rv2),
        .o_req_ready(rr2), .o_data(od2), .o_data_valid(ov2), .i_data_ready(dr2),
        .o_grant(og2), .o_busy(ob2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        logic        v;
        logic [31:0] dat;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                v   = en[d][k] && (ptr[d][k] < cnt[d][k]);
                dat = v ? src[d][k][ptr[d][k]] : 32'h0;
                if (d == 0) begin
                    rv4[k] = v;
                    rd4[k*32 +: 32] = dat;
                end else begin
                    rv2[k] = v;
                    rd2[k*32 +: 32] = dat;
                end
            end
        end
    endtask

    task automatic step();
        logic [2:0] a4, a2;
        #1;
        a4 = rv4 & rr4;
        a2 = rv2 & rr2;
        @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            ptr[0][k] += int'(a4[k]);
            ptr[1][k] += int'(a2[k]);
        end
        drive();
    endtask

    task automatic clear_sources();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                cnt[d][k] = 0;
                ptr[d][k] = 0;
                en[d][k]  = 1'b1;
                for (int i = 0; i < 8; i++) src[d][k][i] = 32'h0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sources();
        dr4 = 1'b1;
        dr2 = 1'b1;
        drive();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_sources();
        cnt[0][0] = 4;
        dr4 = 1'b1;
        dr2 = 1'b1;
        drive();
        @(posedge clk);
        #2;
        if ({od4, ov4, og4, ob4, rr4} !== 39'h0) begin
            errors++;
            $display("FAIL reset_dut4: got %h expected 0", {od4, ov4, og4, ob4, rr4});
        end
        checks++;
        if ({od2, ov2, og2, ob2, rr2} !== 39'h0) begin
            errors++;
            $display("FAIL reset_dut2: got %h expected 0", {od2, ov2, og2, ob2, rr2});
        end
        checks++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic        exp_v [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_d [9] = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'hA4, 32'hA5, 32'h0};
        logic [2:0]  exp_g [9] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                                   3'b010, 3'b010, 3'b010, 3'b000};
        do_reset();
        for (int i = 0; i < 6; i++) src[0][1][i] = 32'hA0 + 32'(i);
        cnt[0][1] = 6;
        drive();
        for (int s = 0; s < 9; s++) begin
            step();
            if (ov4 !== exp_v[s]) begin
                errors++;
                $display("FAIL single_valid[%0d]: got %b expected %b", s, ov4, exp_v[s]);
            end
            checks++;
            if (og4 !== exp_g[s]) begin
                errors++;
                $display("FAIL single_grant[%0d]: got %b expected %b", s, og4, exp_g[s]);
            end
            checks++;
            if (exp_v[s]) begin
                if (od4 !== exp_d[s]) begin
                    errors++;
                    $display("FAIL single_data[%0d]: got %h expected %h", s, od4, exp_d[s]);
                end
                checks++;
            end
        end
    endtask

    task automatic test_round_robin();
        int          phase, owner, round;
        logic [2:0]  exp_g;
        logic [31:0] exp_d;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) src[1][k][i] = 32'h100 * 32'(k + 1) + 32'(i);
            cnt[1][k] = 8;
        end
        drive();
        for (int s = 0; s < 12; s++) begin
            step();
            phase = s % 3;
            owner = (s / 3) % 3;
            round = s / 9;
            exp_g = (phase == 2) ? 3'b000 : (3'b001 << owner);
            exp_d = 32'h100 * 32'(owner + 1) + 32'(2 * round + phase - 1);
            if (og2 !== exp_g) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", s, og2, exp_g);
            end
            checks++;
            if (ov2 !== (phase != 0)) begin
                errors++;
                $display("FAIL rr_valid[%0d]: got %b expected %b", s, ov2, phase != 0);
            end
            checks++;
            if (phase != 0) begin
                if (od2 !== exp_d) begin
                    errors++;
                    $display("FAIL rr_data[%0d]: got %h expected %h", s, od2, exp_d);
                end
                checks++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        src[0][0][0] = 32'h55;
        src[0][0][1] = 32'h56;
        src[0][0][2] = 32'h57;
        cnt[0][0] = 3;
        drive();
        step();
        step();
        if ({ov4, od4} !== {1'b1, 32'h55}) begin
            errors++;
            $display("FAIL bp_first: got %b/%h expected 1/55", ov4, od4);
        end
        checks++;
        dr4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rr4 !== 3'b000) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b expected 000", i, rr4);
            end
            checks++;
            step();
            if ({ov4, od4, og4} !== {1'b1, 32'h55, 3'b001}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %b/%h/%b expected 1/55/001", i, ov4, od4, og4);
            end
            checks++;
            // Requester drops valid while stalled; must not release the grant.
            en[0][0] = (i != 1) && (i != 2);
            drive();
        end
        dr4 = 1'b1;
        #1;
        if (rr4 !== 3'b001) begin
            errors++;
            $display("FAIL bp_ready_back: got %b expected 001", rr4);
        end
        checks++;
        step();
        if ({ov4, od4} !== {1'b1, 32'h56}) begin
            errors++;
            $display("FAIL bp_next: got %b/%h expected 1/56", ov4, od4);
        end
        checks++;
    endtask

    task automatic test_bubble();
        logic        exp_v [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] exp_d [7] = '{32'h0, 32'hB0, 32'hB1, 32'h0, 32'h0, 32'hC0, 32'hC1};
        logic [2:0]  exp_g [7] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b100, 3'b100, 3'b100};
        do_reset();
        src[0][0][0] = 32'hB0;
        src[0][0][1] = 32'hB1;
        cnt[0][0] = 2;
        src[0][2][0] = 32'hC0;
        src[0][2][1] = 32'hC1;
        cnt[0][2] = 2;
        drive();
        for (int s = 0; s < 7; s++) begin
            step();
            if (og4 !== exp_g[s]) begin
                errors++;
                $display("FAIL bubble_grant[%0d]: got %b expected %b", s, og4, exp_g[s]);
            end
            checks++;
            if (ov4 !== exp_v[s]) begin
                errors++;
                $display("FAIL bubble_valid[%0d]: got %b expected %b", s, ov4, exp_v[s]);
            end
            checks++;
            if (exp_v[s]) begin
                if (od4 !== exp_d[s]) begin
                    errors++;
                    $display("FAIL bubble_data[%0d]: got %h expected %h", s, od4, exp_d[s]);
                end
                checks++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            src[0][0][i] = 32'hD0 + 32'(i);
            src[0][1][i] = 32'hE0 + 32'(i);
        end
        cnt[0][0] = 8;
        drive();
        step();
        step();
        if ({ov4, og4} !== {1'b1, 3'b001}) begin
            errors++;
            $display("FAIL mid_pre: got %b/%b expected 1/001", ov4, og4);
        end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if ({od4, ov4, og4, ob4, rr4} !== 39'h0) begin
            errors++;
            $display("FAIL mid_async: got %h expected 0", {od4, ov4, og4, ob4, rr4});
        end
        checks++;
        cnt[0][1] = 8;
        drive();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        if (og4 !== 3'b001) begin
            errors++;
            $display("FAIL mid_first_owner: got %b expected 001", og4);
        end
        checks++;
        step();
        if ({ov4, od4} !== {1'b1, 32'hD1}) begin
            errors++;
            $display("FAIL mid_no_replay: got %b/%h expected 1/d1", ov4, od4);
        end
        checks++;
    endtask

    task automatic test_simul_release();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) src[0][k][i] = 32'h10 * 32'(k + 1) + 32'(i);
            cnt[0][k] = 8;
        end
        en[0][0] = 1'b0;
        en[0][2] = 1'b0;
        drive();
        step();
        if (og4 !== 3'b010) begin
            errors++;
            $display("FAIL simul_first: got %b expected 010", og4);
        end
        checks++;
        en[0][0] = 1'b1;
        en[0][2] = 1'b1;
        drive();
        for (int s = 2; s <= 11; s++) begin
            step();
            if (s == 5) begin
                if ({og4, ov4, od4} !== {3'b000, 1'b1, 32'h23}) begin
                    errors++;
                    $display("FAIL simul_release: got %b/%b/%h expected 000/1/23", og4, ov4, od4);
                end
                checks++;
            end else if (s == 6) begin
                if (og4 !== 3'b100) begin
                    errors++;
                    $display("FAIL simul_next2: got %b expected 100", og4);
                end
                checks++;
            end else if (s == 10) begin
                if (og4 !== 3'b000) begin
                    errors++;
                    $display("FAIL simul_release2: got %b expected 000", og4);
                end
                checks++;
            end else if (s == 11) begin
                if (og4 !== 3'b001) begin
                    errors++;
                    $display("FAIL simul_next0: got %b expected 001", og4);
                end
                checks++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dr4   = 1'b1;
        dr2   = 1'b1;
        rv4   = 3'b000;
        rv2   = 3'b000;
        rd4   = 96'h0;
        rd2   = 96'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_bubble();
        test_reset_mid_burst();
        test_simul_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
